// File: rtl/glove_pkg.sv
// Shared types and constants for the glove sensor text-frame path:
// scheduler state encoding, ASCII bytes, digit-slot indices and clog2.
package glove_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_CONV,
        S_SEND_DIG,
        S_SEND_SEP,
        S_SEND_CR,
        S_SEND_LF,
        S_DONE
    } state_t;

    localparam logic [7:0] CHAR_0     = 8'h30;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_COMMA = 8'h2C;

    // Digit buffer slots in transmit order: MILL, CENT, DECE, UNID.
    localparam logic [1:0] DIG_MILL = 2'd0;
    localparam logic [1:0] DIG_CENT = 2'd1;
    localparam logic [1:0] DIG_UNID = 2'd3;

    typedef logic [3:0][7:0] dig_buf_t;

    function automatic int clog2(input int n);
        int r = 0;
        int v = 1;
        while (v < n) begin
            v = v * 2;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/ascii_frame_scheduler_if.sv
// Byte stream from the frame scheduler to the UART transmitter.
interface ascii_frame_scheduler_if;
    // A byte moves on every cycle with tx_valid_o && tx_ready_i. Once valid is
    // raised, data and valid hold until that transfer; valid never drops
    // without a transfer (reset excepted). Back-to-back transfers are allowed.
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;

    modport master (output tx_data_o, output tx_valid_o, input tx_ready_i);
    modport slave  (input tx_data_o, input tx_valid_o, output tx_ready_i);
endinterface

// File: rtl/ascii_digit_selector.sv
// Chooses the next digit slot of the current channel to transmit, skipping
// leading '0' digits when suppression is enabled; UNID is always sent.
module ascii_digit_selector
    import glove_pkg::*;
#(
    parameter int NDIG       = 3,
    parameter bit SUPPR_ZERO = 1'b0
) (
    input  dig_buf_t   digits_i,
    input  logic [1:0] dig_idx_i,
    input  logic       lead_i,
    output logic [1:0] sel_idx_o,
    output logic       last_o
);
    localparam int FIRST = (NDIG == 4) ? 0 : 1;

    // Lowest slot at or after dig_idx_i that is not a suppressed leading zero.
    always_comb begin
        sel_idx_o = DIG_UNID;
        for (int i = 3; i >= 0; i--) begin
            if (i >= FIRST && i >= int'(dig_idx_i) &&
                !(SUPPR_ZERO && lead_i && i != 3 && digits_i[2'(i)] == CHAR_0)) begin
                sel_idx_o = 2'(i);
            end
        end
        last_o = (sel_idx_o == DIG_UNID);
    end

endmodule

// File: rtl/ascii_frame_scheduler.sv
// Snapshots NCH sensor channels, converts them one by one through the shared
// external ASCII converter and streams "ddd,ddd,...\r\n" to the UART.
module ascii_frame_scheduler
    import glove_pkg::*;
#(
    parameter int         NCH        = 5,
    parameter int         CONV_LAT   = 2,
    parameter int         NDIG       = 3,
    parameter bit         SUPPR_ZERO = 1'b0,
    parameter logic [7:0] SEP_CHAR   = CHAR_COMMA
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [NCH*8-1:0]     canales_i,
    output logic [7:0]           numero_o,
    input  logic [7:0]           unid_i,
    input  logic [7:0]           dece_i,
    input  logic [7:0]           cent_i,
    input  logic [7:0]           mill_i,
    ascii_frame_scheduler_if.master tx,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overrun_o,
    output state_t               state_o
);
    localparam int              CHW       = (clog2(NCH) < 1) ? 1 : clog2(NCH);
    localparam logic [CHW-1:0]  LAST_CH   = CHW'(NCH - 1);
    localparam logic [2:0]      LAT       = 3'(CONV_LAT);
    localparam logic [1:0]      FIRST_DIG = (NDIG == 4) ? DIG_MILL : DIG_CENT;

    state_t           state, state_nx;
    logic [NCH*8-1:0] snap;
    logic [CHW-1:0]   ch;
    logic [2:0]       wait_cnt;
    logic [1:0]       dig_idx;
    logic             lead;
    dig_buf_t         digits;
    logic [1:0]       sel_idx;
    logic             last_dig;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             xfer;

    ascii_digit_selector #(
        .NDIG       (NDIG),
        .SUPPR_ZERO (SUPPR_ZERO)
    ) u_sel (
        .digits_i  (digits),
        .dig_idx_i (dig_idx),
        .lead_i    (lead),
        .sel_idx_o (sel_idx),
        .last_o    (last_dig)
    );

    assign xfer = tx_valid && tx.tx_ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state)
            S_IDLE:      if (start_i) state_nx = S_LOAD;
            S_LOAD:      state_nx = S_WAIT_CONV;
            S_WAIT_CONV: if (wait_cnt == LAT) state_nx = S_SEND_DIG;
            S_SEND_DIG: begin
                tx_valid = 1'b1;
                tx_data  = digits[sel_idx];
                if (tx.tx_ready_i && last_dig) begin
                    state_nx = (ch == LAST_CH) ? S_SEND_CR : S_SEND_SEP;
                end
            end
            S_SEND_SEP: begin
                tx_valid = 1'b1;
                tx_data  = SEP_CHAR;
                if (tx.tx_ready_i) state_nx = S_LOAD;
            end
            S_SEND_CR: begin
                tx_valid = 1'b1;
                tx_data  = CHAR_CR;
                if (tx.tx_ready_i) state_nx = S_SEND_LF;
            end
            S_SEND_LF: begin
                tx_valid = 1'b1;
                tx_data  = CHAR_LF;
                if (tx.tx_ready_i) state_nx = S_DONE;
            end
            S_DONE:      state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    // Datapath; the wait counter reaches CONV_LAT once digits from numero_o are valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap      <= '0;
            ch        <= '0;
            wait_cnt  <= '0;
            dig_idx   <= '0;
            lead      <= 1'b0;
            digits    <= '0;
            numero_o  <= '0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= start_i && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        snap <= canales_i;
                        ch   <= '0;
                    end
                end
                S_LOAD: begin
                    numero_o <= snap[int'(ch)*8 +: 8];
                    wait_cnt <= '0;
                end
                S_WAIT_CONV: begin
                    if (wait_cnt == LAT) begin
                        digits  <= {unid_i, dece_i, cent_i, mill_i};
                        dig_idx <= FIRST_DIG;
                        lead    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                S_SEND_DIG: begin
                    if (xfer) begin
                        dig_idx <= sel_idx + 2'd1;
                        lead    <= 1'b0;
                    end
                end
                S_SEND_SEP: begin
                    if (xfer) ch <= ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign tx.tx_valid_o = tx_valid;
    assign tx.tx_data_o  = tx_data;
    assign busy_o        = (state != S_IDLE);
    assign done_o        = (state == S_DONE);
    assign state_o       = state;

endmodule

// File: tb/tb_ascii_frame_scheduler.sv
// Bench for ascii_frame_scheduler: four configurations side by side, each with
// a behavioural converter, an expected-byte queue and a negedge monitor.
module tb_ascii_frame_scheduler;
    import glove_pkg::*;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic        ready     = 1'b1;
    logic [39:0] canales   = '0;
    logic [39:0] exp_vals  = '0;
    logic        push_req  = 1'b0;
    logic        chk_rst   = 1'b0;
    logic        chk_busy  = 1'b0;
    logic        chk_frame = 1'b0;
    logic        abort     = 1'b0;
    int          exp_ovr   = 0;
    int          n_tests   = 0;
    int          n_fail    = 0;
    logic [3:0]  fin;
    int          nb0;

    localparam logic [39:0] V1 = {8'd100, 8'd42, 8'd7, 8'd0, 8'd255};
    localparam logic [39:0] V2 = {8'd9, 8'd10, 8'd99, 8'd200, 8'd128};

    always #5 clk = ~clk;

    // Instances: 0 defaults, 1 zero suppression, 2/3 one channel, four digits, latency 1 and 7.
    for (genvar g = 0; g < 4; g++) begin : u
        localparam int P_NCH  = (g < 2) ? 5 : 1;
        localparam int P_NDIG = (g < 2) ? 3 : 4;
        localparam int P_LAT  = (g == 3) ? 7 : ((g == 2) ? 1 : 2);
        localparam bit P_SZ   = (g == 1);

        ascii_frame_scheduler_if tx_if ();
        logic [7:0] numero, unid, dece, cent, mill, cv;
        logic       busy, done, overrun;
        state_t     state;
        logic [7:0] pipe [P_LAT];
        logic [7:0] exp_q [$];
        int         nbytes = 0;
        int         ndone  = 0;
        int         novr   = 0;
        logic       prev_stall = 1'b0;
        logic       prev_done  = 1'b0;
        logic [7:0] prev_data  = 8'h00;

        assign tx_if.tx_ready_i = ready;
        assign fin[g] = (ndone != 0);
        if (g == 0) begin : g_nb
            assign nb0 = nbytes;
        end

        ascii_frame_scheduler #(
            .NCH        (P_NCH),
            .CONV_LAT   (P_LAT),
            .NDIG       (P_NDIG),
            .SUPPR_ZERO (P_SZ),
            .SEP_CHAR   (8'h2C)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start_i   (start),
            .canales_i (canales[P_NCH*8-1:0]),
            .numero_o  (numero),
            .unid_i    (unid),
            .dece_i    (dece),
            .cent_i    (cent),
            .mill_i    (mill),
            .tx        (tx_if),
            .busy_o    (busy),
            .done_o    (done),
            .overrun_o (overrun),
            .state_o   (state)
        );

        // Converter model: value delayed P_LAT cycles, then split into decimal ASCII digits.
        always_ff @(posedge clk) begin
            pipe[0] <= numero;
            for (int i = 1; i < P_LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign cv   = pipe[P_LAT-1];
        assign unid = 8'h30 + cv % 8'd10;
        assign dece = 8'h30 + (cv / 8'd10) % 8'd10;
        assign cent = 8'h30 + cv / 8'd100;
        assign mill = 8'h30;

        always @(negedge clk) begin
            logic [7:0] e;
            int         v;
            int         d [4];
            bit         lead;
            if (chk_rst) begin
                n_tests++;
                if ({numero, tx_if.tx_data_o, tx_if.tx_valid_o, busy, done, overrun} !== '0 ||
                    state !== S_IDLE) begin
                    n_fail++;
                    $display("FAIL reset_vals[%0d]: numero=%02h data=%02h valid=%0b busy=%0b done=%0b ovr=%0b state=%0d, required all zero and IDLE",
                             g, numero, tx_if.tx_data_o, tx_if.tx_valid_o, busy, done, overrun, state);
                end
            end
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (push_req) begin
                    for (int k = 0; k < P_NCH; k++) begin
                        v    = int'(exp_vals[k*8 +: 8]);
                        d[0] = v / 1000;
                        d[1] = (v / 100) % 10;
                        d[2] = (v / 10) % 10;
                        d[3] = v % 10;
                        lead = P_SZ;
                        if (k > 0) exp_q.push_back(8'h2C);
                        for (int j = 4 - P_NDIG; j < 4; j++) begin
                            if (d[j] != 0 || j == 3) lead = 1'b0;
                            if (!lead) exp_q.push_back(8'(8'h30 + d[j]));
                        end
                    end
                    exp_q.push_back(8'h0D);
                    exp_q.push_back(8'h0A);
                end
                if (prev_stall) begin
                    n_tests++;
                    if (tx_if.tx_valid_o !== 1'b1 || tx_if.tx_data_o !== prev_data) begin
                        n_fail++;
                        $display("FAIL hold[%0d]: valid=%0b data=%02h, required valid=1 data=%02h",
                                 g, tx_if.tx_valid_o, tx_if.tx_data_o, prev_data);
                    end
                end
                if (tx_if.tx_valid_o && tx_if.tx_ready_i) begin
                    n_tests++;
                    nbytes++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_byte[%0d]: got %02h, required no byte", g, tx_if.tx_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (tx_if.tx_data_o !== e) begin
                            n_fail++;
                            $display("FAIL byte[%0d] #%0d: got %02h, required %02h", g, nbytes, tx_if.tx_data_o, e);
                        end
                    end
                end
                if (done) ndone++;
                if (overrun) novr++;
                if (chk_busy) begin
                    n_tests++;
                    if (busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL busy_after_start[%0d]: got %0b, required 1", g, busy);
                    end
                end
                if (prev_done) begin
                    n_tests++;
                    if (busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL busy_after_done[%0d]: got %0b, required 0", g, busy);
                    end
                end
                if (chk_frame) begin
                    n_tests += 3;
                    if (exp_q.size() != 0) begin
                        n_fail++;
                        $display("FAIL frame_len[%0d]: %0d bytes missing, required 0", g, exp_q.size());
                    end
                    if (ndone != 1) begin
                        n_fail++;
                        $display("FAIL done_count[%0d]: got %0d, required 1", g, ndone);
                    end
                    if (novr != exp_ovr) begin
                        n_fail++;
                        $display("FAIL overrun_count[%0d]: got %0d, required %0d", g, novr, exp_ovr);
                    end
                end
                if (chk_frame || abort) begin
                    exp_q.delete();
                    nbytes = 0;
                    ndone  = 0;
                    novr   = 0;
                end
                prev_stall = tx_if.tx_valid_o && !tx_if.tx_ready_i;
                prev_data  = tx_if.tx_data_o;
                prev_done  = done;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input logic [39:0] vals);
        canales  = vals;
        exp_vals = vals;
        start    = 1'b1;
        push_req = 1'b1;
        tick();
        start    = 1'b0;
        push_req = 1'b0;
    endtask

    task automatic run_frame(input logic [39:0] vals, input bit bp, input bit ovr);
        int guard;
        issue_start(vals);
        chk_busy = 1'b1;
        if (ovr) canales = {5{8'd9}};
        tick();
        chk_busy = 1'b0;
        if (ovr) begin
            tick();
            start   = 1'b1;
            exp_ovr = 1;
            tick();
            start   = 1'b0;
        end
        guard = 0;
        while (fin != 4'hF && guard < 5000) begin
            ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
            tick();
            guard++;
        end
        ready = 1'b1;
        if (guard >= 5000) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: frame unfinished after %0d cycles, fin=%b, required 1111", guard, fin);
        end
        repeat (8) tick();
        chk_frame = 1'b1;
        tick();
        chk_frame = 1'b0;
        exp_ovr   = 0;
    endtask

    function automatic logic [39:0] rand_vals();
        logic [39:0] r;
        for (int k = 0; k < 5; k++) begin
            r[k*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 9))
                                                       : 8'($urandom_range(0, 255));
        end
        return r;
    endfunction

    initial begin
        int guard;
        rst_n = 1'b0;
        tick();
        tick();
        chk_rst = 1'b1;
        tick();
        chk_rst = 1'b0;
        rst_n   = 1'b1;
        tick();

        run_frame(V1, 1'b0, 1'b0);
        run_frame(V2, 1'b0, 1'b0);
        run_frame(V1, 1'b1, 1'b0);
        run_frame(V1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) run_frame(rand_vals(), (i % 2) == 0, 1'b0);

        // Reset while byte 8 of the default-configuration frame is on the bus.
        issue_start(V1);
        guard = 0;
        while (nb0 < 7 && guard < 500) begin
            tick();
            guard++;
        end
        if (guard >= 500) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout_byte8: %0d bytes seen, required 7", nb0);
        end
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        chk_rst = 1'b1;
        abort   = 1'b1;
        tick();
        chk_rst = 1'b0;
        abort   = 1'b0;
        tick();
        run_frame(V1, 1'b0, 1'b0);
        run_frame(V2, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
